fetch_unit: RTL and testbench

Instruction-fetch stage feeding the instruction decoder. Holds the 64-bit PC, issues word requests to instruction memory over a valid/ready handshake, buffers returned instructions in a 2-entry queue, and presents them to decode as an instruction/PC pair with valid/ready flow control. It also resolves branch redirects from the decoder's control outputs (Uncondbranch, Branch) and the ALU zero flag, and discards any fetch already in flight.

---
 rtl/fetch_unit_pkg.sv | 11 +
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit_queue.sv | 38 +++
 rtl/fetch_unit.sv | 61 ++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, fetch state encoding and queue entry type for the fetch stage
package fetch_unit_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam int ADDR_WIDTH = 64;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = '0;
  typedef enum logic [1:0] {REQ, WAIT, DROP} fetch_state_e;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, decode and branch-resolution signals of the fetch stage
interface fetch_unit_if;
  import fetch_unit_pkg::*;
  logic imem_req_valid;
  logic imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;
  logic if_id_valid;
  logic if_id_ready;
  logic [INSTR_WIDTH-1:0] if_id_instruction;
  logic [ADDR_WIDTH-1:0] if_id_pc;
  logic uncond_branch;
  logic branch;
  logic branch_invert;
  logic alu_zero;
  logic [ADDR_WIDTH-1:0] branch_pc;
  logic [25:0] branch_offset;
  modport master (
    output imem_req_valid, imem_addr, if_id_valid, if_id_instruction, if_id_pc,
    input imem_req_ready, imem_rsp_valid, imem_rsp_data, if_id_ready,
    input uncond_branch, branch, branch_invert, alu_zero, branch_pc, branch_offset
  );
  modport slave (
    input imem_req_valid, imem_addr, if_id_valid, if_id_instruction, if_id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_id_ready,
    output uncond_branch, branch, branch_invert, alu_zero, branch_pc, branch_offset
  );
endinterface

// File: rtl/fetch_unit_queue.sv
// fetch_queue: 2-entry FIFO of {pc, instruction}; head is always entry 0 so the output is registered
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);
  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d, idx;
  logic pop;
  // a pop shifts entry 1 forward, so the push slot is the post-pop count
  always_comb begin
    pop = pop_i & (cnt_q != 2'd0);
    idx = cnt_q - {1'b0, pop};
    e0_d = (push_i && idx == 2'd0) ? data_i : pop ? e1_q : e0_q;
    e1_d = (push_i && idx != 2'd0) ? data_i : e1_q;
    cnt_d = flush_i ? 2'd0 : idx + {1'b0, push_i};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
    end
  end
  assign count_o = cnt_q;
  assign head_o = e0_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, single-outstanding instruction fetch, 2-entry buffer to decode and branch redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  fetch_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d, target;
  logic [25:0] off;
  logic [1:0] count;
  logic [2:0] occ;
  logic pop, taken, req_hs, push, outstanding;
  fetch_entry_t head;
  always_comb begin
    off = bus.branch_offset;
    pop = bus.if_id_valid & bus.if_id_ready;
    occ = {1'b0, count} + {2'b0, state_q != REQ} - {2'b0, pop};
    taken = bus.uncond_branch | (bus.branch & (bus.alu_zero ^ bus.branch_invert));
    target = bus.branch_pc + (bus.uncond_branch ? {{36{off[25]}}, off, 2'b00}
                                                : {{43{off[18]}}, off[18:0], 2'b00});
    req_hs = bus.imem_req_valid & bus.imem_req_ready;
    push = (state_q == WAIT) & bus.imem_rsp_valid & ~taken;
    // still owed a response after this edge: either just issued or not yet returned
    outstanding = req_hs | ((state_q != REQ) & ~bus.imem_rsp_valid);
    pc_d = taken ? target : req_hs ? pc_q + 64'd4 : pc_q;
    req_pc_d = req_hs ? pc_q : req_pc_q;
    state_d = taken ? (outstanding ? DROP : REQ)
            : req_hs ? WAIT
            : (state_q != REQ && bus.imem_rsp_valid) ? REQ : state_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= REQ;
      pc_q <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end
  fetch_queue u_queue (
    .clk(clk),
    .reset(reset),
    .push_i(push),
    .pop_i(pop),
    .flush_i(taken),
    .data_i('{pc: req_pc_q, instr: bus.imem_rsp_data}),
    .count_o(count),
    .head_o(head)
  );
  assign bus.imem_req_valid = ~reset & (state_q == REQ) & (occ < 3'd2);
  assign bus.imem_addr = pc_q;
  assign bus.if_id_valid = count != 2'd0;
  assign bus.if_id_instruction = head.instr;
  assign bus.if_id_pc = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with a latency-programmable memory and a reference PC model
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam logic [63:0] RPC = 64'h1000;
  typedef struct {
    logic [63:0] a;
    int t;
  } pend_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;
  int lat = 1;
  int cyc = 0;
  int n_pop = 0;
  int p0;
  logic [63:0] model_pc = RPC;
  logic [63:0] mon_e;
  logic mon_tk;
  logic [63:0] exp_q[$];
  logic [63:0] req_log[$];
  pend_t pend[$];

  fetch_unit_if bus ();
  fetch_unit #(.RESET_PC(RPC)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] idata(input logic [63:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [63:0] tgt(input logic u, input logic [63:0] bpc, input logic [25:0] off);
    logic signed [25:0] s26;
    logic signed [18:0] s19;
    s26 = off;
    s19 = off[18:0];
    return u ? bpc + (64'(s26) <<< 2) : bpc + (64'(s19) <<< 2);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect(input logic u, input logic b, input logic inv, input logic z,
                          input logic [63:0] bpc, input logic [25:0] off);
    bus.if_id_ready = 1'b0;
    bus.uncond_branch = u;
    bus.branch = b;
    bus.branch_invert = inv;
    bus.alu_zero = z;
    bus.branch_pc = bpc;
    bus.branch_offset = off;
    step(1);
    bus.uncond_branch = 1'b0;
    bus.branch = 1'b0;
    bus.branch_invert = 1'b0;
    bus.alu_zero = 1'b0;
    req_log.delete();
  endtask

  task automatic expect_next_req(input string name, input logic [63:0] addr);
    for (int i = 0; i < 20 && req_log.size() == 0; i++) step(1);
    tests_run++;
    if (req_log.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: no request seen, expected addr %h", name, addr);
    end else if (req_log[0] !== addr) begin
      tests_failed++;
      $display("FAIL %s: got addr %h expected %h", name, req_log[0], addr);
    end
  endtask

  task automatic test_reset();
    step(2);
    tests_run += 5;
    if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_req_valid: got %b expected 0", bus.imem_req_valid); end
    if (bus.if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_if_id_valid: got %b expected 0", bus.if_id_valid); end
    if (bus.if_id_instruction !== 32'h0) begin tests_failed++; $display("FAIL rst_instr: got %h expected 0", bus.if_id_instruction); end
    if (bus.if_id_pc !== 64'h0) begin tests_failed++; $display("FAIL rst_pc: got %h expected 0", bus.if_id_pc); end
    if (bus.imem_addr !== RPC) begin tests_failed++; $display("FAIL rst_addr: got %h expected %h", bus.imem_addr, RPC); end
    reset = 1'b0;
    #1;
    tests_run += 2;
    if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL first_req_valid: got %b expected 1", bus.imem_req_valid); end
    if (bus.imem_addr !== RPC) begin tests_failed++; $display("FAIL first_req_addr: got %h expected %h", bus.imem_addr, RPC); end
  endtask

  task automatic test_stream();
    lat = 1;
    bus.if_id_ready = 1'b1;
    p0 = n_pop;
    step(30);
    tests_run++;
    if (n_pop - p0 < 10) begin tests_failed++; $display("FAIL stream_count: got %0d expected >=10", n_pop - p0); end
  endtask

  task automatic test_stall();
    bus.if_id_ready = 1'b0;
    step(5);
    tests_run += 2;
    if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_req_valid: got %b expected 0", bus.imem_req_valid); end
    if (bus.if_id_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_if_id_valid: got %b expected 1", bus.if_id_valid); end
    bus.if_id_ready = 1'b1;
    p0 = n_pop;
    step(20);
    tests_run++;
    if (n_pop - p0 < 6) begin tests_failed++; $display("FAIL stall_release_count: got %0d expected >=6", n_pop - p0); end
  endtask

  task automatic test_uncond();
    bus.if_id_ready = 1'b1;
    step(3);
    redirect(1'b1, 1'b0, 1'b0, 1'b0, 64'h2000, 26'h3FFFFFE);
    tests_run++;
    if (bus.if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL uncond_flush: got %b expected 0", bus.if_id_valid); end
    bus.if_id_ready = 1'b1;
    expect_next_req("uncond_target", 64'h1FF8);
    step(10);
  endtask

  task automatic test_cond();
    redirect(1'b0, 1'b1, 1'b0, 1'b0, 64'h500, 26'd4);
    bus.if_id_ready = 1'b1;
    p0 = n_pop;
    step(10);
    tests_run++;
    if (n_pop - p0 < 3) begin tests_failed++; $display("FAIL cond_not_taken_count: got %0d expected >=3", n_pop - p0); end
    redirect(1'b0, 1'b1, 1'b0, 1'b1, 64'h100, 26'd4);
    bus.if_id_ready = 1'b1;
    expect_next_req("cbz_target", 64'h110);
    step(8);
    redirect(1'b0, 1'b1, 1'b1, 1'b0, 64'h300, 26'h0AFFFFF);
    bus.if_id_ready = 1'b1;
    expect_next_req("cbnz_target", 64'h2FC);
    step(8);
  endtask

  task automatic test_drop();
    lat = 3;
    bus.if_id_ready = 1'b1;
    step(6);
    req_log.delete();
    for (int i = 0; i < 20 && req_log.size() == 0; i++) step(1);
    tests_run++;
    if (req_log.size() == 0) begin tests_failed++; $display("FAIL drop_setup: no request seen, expected one"); end
    redirect(1'b1, 1'b0, 1'b0, 1'b0, 64'h4000, 26'd8);
    bus.if_id_ready = 1'b1;
    expect_next_req("drop_target", 64'h4020);
    p0 = n_pop;
    step(20);
    tests_run++;
    if (n_pop - p0 < 2) begin tests_failed++; $display("FAIL drop_resume_count: got %0d expected >=2", n_pop - p0); end
  endtask

  task automatic test_reset_mid();
    lat = 6;
    bus.if_id_ready = 1'b0;
    req_log.delete();
    for (int i = 0; i < 40 && !(bus.if_id_valid && req_log.size() > 0); i++) step(1);
    reset = 1'b1;
    #1;
    pend.delete();
    exp_q.delete();
    model_pc = RPC;
    bus.imem_rsp_valid = 1'b0;
    tests_run += 5;
    if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_req_valid: got %b expected 0", bus.imem_req_valid); end
    if (bus.if_id_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_if_id_valid: got %b expected 0", bus.if_id_valid); end
    if (bus.if_id_instruction !== 32'h0) begin tests_failed++; $display("FAIL mid_rst_instr: got %h expected 0", bus.if_id_instruction); end
    if (bus.if_id_pc !== 64'h0) begin tests_failed++; $display("FAIL mid_rst_pc: got %h expected 0", bus.if_id_pc); end
    if (bus.imem_addr !== RPC) begin tests_failed++; $display("FAIL mid_rst_addr: got %h expected %h", bus.imem_addr, RPC); end
    step(2);
    lat = 1;
    bus.if_id_ready = 1'b1;
    req_log.delete();
    reset = 1'b0;
    expect_next_req("restart_addr", RPC);
    p0 = n_pop;
    step(12);
    tests_run++;
    if (n_pop - p0 < 4) begin tests_failed++; $display("FAIL restart_count: got %0d expected >=4", n_pop - p0); end
  endtask

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    bus.if_id_ready = 1'b0;
    bus.uncond_branch = 1'b0;
    bus.branch = 1'b0;
    bus.branch_invert = 1'b0;
    bus.alu_zero = 1'b0;
    bus.branch_pc = '0;
    bus.branch_offset = '0;
    fork
      forever begin
        @(posedge clk);
        #1;
        cyc++;
        bus.imem_rsp_valid = 1'b0;
        if (reset) pend.delete();
        else if (pend.size() > 0 && pend[0].t <= cyc) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data = idata(pend[0].a);
          void'(pend.pop_front());
        end
      end
      forever begin
        @(negedge clk);
        if (!reset) begin
          mon_tk = bus.uncond_branch | (bus.branch & (bus.alu_zero ^ bus.branch_invert));
          if (bus.imem_req_valid && bus.imem_req_ready) begin
            tests_run++;
            if (bus.imem_addr !== model_pc) begin
              tests_failed++;
              $display("FAIL req_addr: got %h expected %h", bus.imem_addr, model_pc);
            end
            req_log.push_back(bus.imem_addr);
            pend.push_back('{a: bus.imem_addr, t: cyc + lat});
            if (!mon_tk) exp_q.push_back(model_pc);
            model_pc += 64'd4;
          end
          if (bus.if_id_valid && bus.if_id_ready && !mon_tk) begin
            tests_run++;
            n_pop++;
            if (exp_q.size() == 0) begin
              tests_failed++;
              $display("FAIL unexpected_instr: got pc %h expected none", bus.if_id_pc);
            end else begin
              mon_e = exp_q.pop_front();
              if (bus.if_id_pc !== mon_e || bus.if_id_instruction !== idata(mon_e)) begin
                tests_failed++;
                $display("FAIL deliver: got pc %h instr %h expected pc %h instr %h",
                         bus.if_id_pc, bus.if_id_instruction, mon_e, idata(mon_e));
              end
            end
          end
          if (mon_tk) begin
            model_pc = tgt(bus.uncond_branch, bus.branch_pc, bus.branch_offset);
            exp_q.delete();
          end
        end
      end
    join_none
    test_reset();
    test_stream();
    test_stall();
    test_uncond();
    test_cond();
    test_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
